led_lights: RTL and testbench
=============================

LED_LIGHTS -- requirements
Module: led_lights

Interface
REQ-001 Parameter: BLINK_DIV, default 25_000_000, cycles per half-period of fault blink (only used when LED_LIGHTS_BLINK_EN defined); minimum 1.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: LEDs  input  7  lamp request vector.
- Bit 6=Rm, 5=Ym, 4=Gm, 3=Rs, 2=Ys, 1=Gs, 0=Walk.
REQ-005 Port: fault_clr  input  1  request to leave latched fault state.
REQ-006 Ports: Rm, Ym, Gm  output  1 each  main-road red/yellow/green lamp drive.
REQ-007 Ports: Rs, Ys, Gs  output  1 each  side-road red/yellow/green lamp drive.
REQ-008 Port: Walk  output  1  pedestrian walk lamp drive.
REQ-009 Port: fault  output  1  latched conflict indicator.
REQ-010 Port: fault_cnt  output  8  saturating count of detected conflicts.

Function
REQ-011 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-012 Normal mode: each lamp output SHALL equal its LEDs bit (REQ-004 mapping) sampled at the previous rising edge; latency 1 cycle.
REQ-013 LEDs=0 is legal; all lamps dark one cycle later.
REQ-014 Conflict SHALL be detected on any of these:
- more than one of LEDs[6:4] set;
- more than one of LEDs[3:1] set;
- (Gm|Ym) and (Gs|Ys) both set;
- Walk together with any of Gm, Ym, Gs, Ys.
REQ-015 Any one-hot LEDs value SHALL be legal.
REQ-016 On a conflict edge, the next cycle SHALL have:
- fault=1, Rm=Rs=1, all other lamps 0;
- fault_cnt incremented by 1, saturating at 255.
REQ-017 While fault=1: LEDs ignored for lamp drive; Rm=Rs=1 (or blinking per REQ-024); Ym=Gm=Ys=Gs=Walk=0.
REQ-018 Further conflicts while fault=1 SHALL still increment fault_cnt (saturating).
REQ-019 Leaving fault:
- fault_clr=1 with legal LEDs on an edge: fault=0 next cycle and lamps resume REQ-012 mapping from that same sample.
- fault_clr=1 with a conflicting LEDs sample: fault remains 1 (conflict wins) and fault_cnt increments.
REQ-020 fault_clr while fault=0 SHALL have no effect.

Reset
REQ-021 rst=1 at a rising edge SHALL force all lamps 0, fault=0, fault_cnt=0 and the blink divider/phase to 0; takes priority over all other inputs, including mid-fault.
REQ-022 First edge with rst=0 SHALL resume REQ-012 sampling of LEDs.

Configuration
REQ-023 Macro LED_LIGHTS_BLINK_EN selects fault-state red behaviour.
REQ-024 Defined: in fault, Rm and Rs blink together.
- On for the first BLINK_DIV cycles after fault entry, then toggle every BLINK_DIV cycles.
- Divider restarts at fault entry.
REQ-025 Undefined: in fault, Rm=Rs=1 steady; no divider logic is synthesized and BLINK_DIV is unused.

Verification
REQ-026 rst=1 for 2 cycles with LEDs=7'h7F -> all outputs 0, fault_cnt=0.
REQ-027 LEDs=0, then 7'b1000000, 0100000, 0010000, 0001000, 0000100, 0000010, 0000001, each held 5 cycles -> exactly the matching lamp (Rm..Walk) is 1, one cycle after each change; fault=0 throughout.
REQ-028 LEDs=7'b0010010 (Gm+Gs) -> next cycle fault=1, Rm=Rs=1 (steady without macro), others 0, fault_cnt=1.
REQ-029 In fault, LEDs=7'b1000000 with fault_clr=1 -> next cycle fault=0, Rm=1, Rs=0; LEDs=7'b0100001 with fault_clr=1 -> fault stays 1, fault_cnt increments.
REQ-030 Hold a conflicting LEDs for 300 cycles -> fault_cnt saturates at 255; then rst=1 -> fault=0, fault_cnt=0.
REQ-031 With LED_LIGHTS_BLINK_EN and BLINK_DIV=4, trigger a conflict -> Rm/Rs on 4 cycles, off 4 cycles, repeating.

Source files
------------

// File: rtl/led_lights.sv
// Registered traffic-lamp driver with conflict detection, latched fault state and a saturating fault counter.
// Define LED_LIGHTS_BLINK_EN to make the fault-state red lamps blink with a half-period of BLINK_DIV cycles.
module led_lights #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] LEDs,
    input  logic       fault_clr,
    output logic       Rm,
    output logic       Ym,
    output logic       Gm,
    output logic       Rs,
    output logic       Ys,
    output logic       Gs,
    output logic       Walk,
    output logic       fault,
    output logic [7:0] fault_cnt
);

    typedef enum logic {
        ST_NORMAL,
        ST_FAULT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [6:0] lamps;
    logic [6:0] lamps_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       conflict;
    logic       red_on;

    always_comb begin
        logic main_multi;
        logic side_multi;
        logic main_go;
        logic side_go;
        main_multi = (LEDs[6] & LEDs[5]) | (LEDs[6] & LEDs[4]) | (LEDs[5] & LEDs[4]);
        side_multi = (LEDs[3] & LEDs[2]) | (LEDs[3] & LEDs[1]) | (LEDs[2] & LEDs[1]);
        main_go    = LEDs[5] | LEDs[4];
        side_go    = LEDs[2] | LEDs[1];
        conflict   = main_multi | side_multi | (main_go & side_go)
                   | (LEDs[0] & (main_go | side_go));
    end

    // A conflict always wins, even against a simultaneous fault_clr.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (conflict) begin
            state_next = ST_FAULT;
        end else if (state == ST_FAULT && !fault_clr) begin
            state_next = ST_FAULT;
        end else begin
            state_next = ST_NORMAL;
        end
        if (conflict && cnt != 8'hFF) begin
            cnt_next = cnt + 8'd1;
        end
    end

`ifdef LED_LIGHTS_BLINK_EN
    localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BLINK_DIV - 1);

    logic [DW-1:0] div;
    logic [DW-1:0] div_next;
    logic          phase;
    logic          phase_next;

    // Phase 0 means lamps on; the divider restarts only on the normal-to-fault transition.
    always_comb begin
        div_next   = '0;
        phase_next = 1'b0;
        if (state_next == ST_FAULT && state == ST_FAULT) begin
            if (div == DIV_LAST) begin
                div_next   = '0;
                phase_next = ~phase;
            end else begin
                div_next   = div + DW'(1);
                phase_next = phase;
            end
        end
        red_on = ~phase_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div   <= '0;
            phase <= 1'b0;
        end else begin
            div   <= div_next;
            phase <= phase_next;
        end
    end
`else
    // Steady red; BLINK_DIV only matters when blinking is built in.
    assign red_on = (BLINK_DIV > 0);
`endif

    always_comb begin
        lamps_next = LEDs;
        if (state_next == ST_FAULT) begin
            lamps_next = {red_on, 2'b00, red_on, 3'b000};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_NORMAL;
            lamps <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            lamps <= lamps_next;
            cnt   <= cnt_next;
        end
    end

    assign {Rm, Ym, Gm, Rs, Ys, Gs, Walk} = lamps;
    assign fault     = (state == ST_FAULT);
    assign fault_cnt = cnt;

endmodule

// File: tb/tb_led_lights.sv
// Randomized and directed bench for led_lights against a cycle-level behavioural model.
module tb_led_lights;

    localparam int BDIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] LEDs;
    logic       fault_clr;
    logic       Rm, Ym, Gm, Rs, Ys, Gs, Walk;
    logic       fault;
    logic [7:0] fault_cnt;

    int checks   = 0;
    int failures = 0;

    bit         m_fault;
    int         m_cnt;
    logic [6:0] m_lamps;
    int         m_age;

    always #5 clk = ~clk;

    led_lights #(.BLINK_DIV(BDIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .LEDs     (LEDs),
        .fault_clr(fault_clr),
        .Rm       (Rm),
        .Ym       (Ym),
        .Gm       (Gm),
        .Rs       (Rs),
        .Ys       (Ys),
        .Gs       (Gs),
        .Walk     (Walk),
        .fault    (fault),
        .fault_cnt(fault_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_conflict(input logic [6:0] v);
        int  n_main;
        int  n_side;
        bit  main_go;
        bit  side_go;
        n_main  = $countones(v[6:4]);
        n_side  = $countones(v[3:1]);
        main_go = v[5] || v[4];
        side_go = v[2] || v[1];
        return (n_main > 1) || (n_side > 1) || (main_go && side_go)
            || (v[0] && (main_go || side_go));
    endfunction

    function automatic bit red_lit(input int age);
`ifdef LED_LIGHTS_BLINK_EN
        return ((age / BDIV) % 2) == 0;
`else
        return (age >= 0);
`endif
    endfunction

    task automatic model_edge(input logic r, input logic [6:0] v, input logic clr);
        if (r) begin
            m_fault = 0;
            m_cnt   = 0;
            m_lamps = '0;
            m_age   = 0;
        end else if (is_conflict(v) || (m_fault && !clr)) begin
            m_age   = m_fault ? m_age + 1 : 0;
            m_fault = 1;
            if (is_conflict(v) && m_cnt < 255) m_cnt++;
            m_lamps = red_lit(m_age) ? 7'b1001000 : 7'b0000000;
        end else begin
            m_fault = 0;
            m_lamps = v;
        end
    endtask

    task automatic step(input logic r, input logic [6:0] v, input logic clr);
        rst       = r;
        LEDs      = v;
        fault_clr = clr;
        @(posedge clk);
        model_edge(r, v, clr);
        #1;
        check("lamps", {25'd0, Rm, Ym, Gm, Rs, Ys, Gs, Walk}, {25'd0, m_lamps});
        check("fault", {31'd0, fault}, {31'd0, m_fault});
        check("fault_cnt", {24'd0, fault_cnt}, m_cnt);
    endtask

    initial begin
        logic [6:0] v;
        logic [6:0] onehot;
        rst       = 1'b1;
        LEDs      = 7'h7F;
        fault_clr = 1'b0;
        m_fault   = 0;
        m_cnt     = 0;
        m_lamps   = '0;
        m_age     = 0;

        step(1'b1, 7'h7F, 1'b0);
        step(1'b1, 7'h7F, 1'b0);
        check("reset_all_zero", {23'd0, Rm, Ym, Gm, Rs, Ys, Gs, Walk, fault, fault_cnt}, 32'd0);

        for (int k = 0; k < 5; k++) step(1'b0, 7'b0000000, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            onehot = 7'b0000001 << i;
            for (int k = 0; k < 5; k++) step(1'b0, onehot, 1'b0);
            check("onehot_lamp", {25'd0, Rm, Ym, Gm, Rs, Ys, Gs, Walk}, {25'd0, onehot});
        end

        step(1'b0, 7'b0010010, 1'b0);
        check("gm_gs_fault", {31'd0, fault}, 32'd1);
        check("gm_gs_cnt", {24'd0, fault_cnt}, 32'd1);
        for (int k = 0; k < 6; k++) step(1'b0, 7'b0000100, 1'b0);
        step(1'b0, 7'b1000000, 1'b1);
        check("clr_leave", {30'd0, fault, Rm, Rs}, 32'b010);

        step(1'b0, 7'b0000001, 1'b1);
        step(1'b0, 7'b0010010, 1'b0);
        step(1'b0, 7'b0100001, 1'b1);
        check("clr_conflict_stays", {31'd0, fault}, 32'd1);
        check("clr_conflict_cnt", {24'd0, fault_cnt}, 32'd3);

        for (int k = 0; k < 300; k++) step(1'b0, 7'b1100000, 1'b0);
        check("cnt_saturate", {24'd0, fault_cnt}, 32'd255);
        step(1'b1, 7'b1100000, 1'b0);
        check("rst_mid_fault", {23'd0, fault, fault_cnt}, 32'd0);

        for (int n = 0; n < 1500; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) begin
                v = 7'b0000001 << $urandom_range(0, 6);
            end else if (sel == 4) begin
                v = '0;
            end else begin
                v = 7'($urandom);
            end
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, v,
                 ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
